// File: rtl/key_cmd_queue.sv
// key_cmd_queue: synchronizes raw PS/2 driver events and decodes them into
// LEFT/RIGHT/START/QUIT commands. Typematic repeats are dropped, and the
// commands are buffered in a small first-word-fall-through FIFO.
module key_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             done,
    input  logic [7:0]       key,
    input  logic             key_released,
    input  logic             expand_key,
    input  logic             cmd_rd,
    input  logic             clr_ovf,
    output logic             cmd_valid,
    output logic [2:0]       cmd,
    output logic [3:0]       held,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0] CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic             d1, d2, d3;
    logic [7:0]       key1, key2;
    logic             rel1, rel2;
    logic             exp1, exp2;
    logic             ev;
    logic [2:0]       dec_cmd;
    logic [3:0]       dec_oh;
    logic             push_req;
    logic [2:0]       push_cmd;
    logic [2:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_pop, do_push, drop;

    // Synchronizer for done, with the event fields carried alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1   <= 1'b0;
            d2   <= 1'b0;
            d3   <= 1'b0;
            key1 <= 8'h00;
            key2 <= 8'h00;
            rel1 <= 1'b0;
            rel2 <= 1'b0;
            exp1 <= 1'b0;
            exp2 <= 1'b0;
        end else begin
            d1   <= done;
            d2   <= d1;
            d3   <= d2;
            key1 <= key;
            key2 <= key1;
            rel1 <= key_released;
            rel2 <= rel1;
            exp1 <= expand_key;
            exp2 <= exp1;
        end
    end

    // One strobe per done rising edge, whatever the pulse width.
    assign ev = d2 & ~d3;

    // Map the synchronized scan code to a command number and a one-hot mask.
    always_comb begin
        dec_cmd = 3'd0;
        if (exp2) begin
            case (key2)
                8'h6B:   dec_cmd = 3'd1;
                8'h74:   dec_cmd = 3'd2;
                default: dec_cmd = 3'd0;
            endcase
        end else begin
            case (key2)
                8'h1C:   dec_cmd = 3'd1;
                8'h23:   dec_cmd = 3'd2;
                8'h29:   dec_cmd = 3'd3;
                8'h5A:   dec_cmd = 3'd3;
                8'h76:   dec_cmd = 3'd4;
                default: dec_cmd = 3'd0;
            endcase
        end
        case (dec_cmd)
            3'd1:    dec_oh = 4'b0001;
            3'd2:    dec_oh = 4'b0010;
            3'd3:    dec_oh = 4'b0100;
            3'd4:    dec_oh = 4'b1000;
            default: dec_oh = 4'b0000;
        endcase
    end

    // Held-key filter: a make only pushes when its key was not already down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held     <= 4'b0000;
            push_req <= 1'b0;
            push_cmd <= 3'd0;
        end else if (!en) begin
            held     <= 4'b0000;
            push_req <= 1'b0;
        end else if (ev && (dec_oh != 4'b0000)) begin
            if (rel2) begin
                held     <= held & ~dec_oh;
                push_req <= 1'b0;
            end else if ((held & dec_oh) == 4'b0000) begin
                held     <= held | dec_oh;
                push_req <= 1'b1;
                push_cmd <= dec_cmd;
            end else begin
                push_req <= 1'b0;
            end
        end else begin
            push_req <= 1'b0;
        end
    end

    assign do_pop  = cmd_rd && (count != {(PTR_W+1){1'b0}});
    assign do_push = push_req && ((count != FULL_CNT) || do_pop);
    assign drop    = push_req && (count == FULL_CNT) && !do_pop;

    // FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
            count  <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 3'd0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_cmd;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop on the same cycle wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow;
        end
    end

    assign cmd_valid = (count != {(PTR_W+1){1'b0}});
    assign cmd       = cmd_valid ? mem[rd_ptr] : 3'd0;

endmodule

// File: tb/tb_key_cmd_queue.sv
// Scoreboard bench for key_cmd_queue: the stimulus side runs a high-level
// model (held set plus a bounded command list), and a monitor checks every pop.
module tb_key_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       done = 1'b0;
    logic [7:0] key = 8'h00;
    logic       key_released = 1'b0;
    logic       expand_key = 1'b0;
    logic       cmd_rd = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [3:0] held;
    logic [2:0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic [3:0] m_held = 4'b0000;
    logic       m_ovf = 1'b0;
    int last_pop = 0;

    key_cmd_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .done(done), .key(key),
        .key_released(key_released), .expand_key(expand_key),
        .cmd_rd(cmd_rd), .clr_ovf(clr_ovf), .cmd_valid(cmd_valid),
        .cmd(cmd), .held(held), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    // Inputs change 2 time units after a rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int map_cmd(input logic [7:0] k, input logic x);
        if (x) return (k == 8'h6B) ? 1 : (k == 8'h74) ? 2 : 0;
        if (k == 8'h1C) return 1;
        if (k == 8'h23) return 2;
        if (k == 8'h29 || k == 8'h5A) return 3;
        if (k == 8'h76) return 4;
        return 0;
    endfunction

    // Reference model of one serialized event.
    task automatic model_event(input logic [7:0] k, input logic r, input logic x);
        int c;
        c = map_cmd(k, x);
        if (!en) begin
            m_held = 4'b0000;
        end else if (c != 0) begin
            if (r) begin
                m_held[c-1] = 1'b0;
            end else if (!m_held[c-1]) begin
                m_held[c-1] = 1'b1;
                if (exp_q.size() < DEPTH) exp_q.push_back(c);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [7:0] k, input logic r, input logic x, input int w);
        key = k; key_released = r; expand_key = x; done = 1'b1;
        model_event(k, r, x);
        repeat (w) tick();
        done = 1'b0;
        repeat (4) tick();
    endtask

    task automatic pop1();
        cmd_rd = 1'b1;
        tick();
        cmd_rd = 1'b0;
        tick();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, int'(count), exp_q.size());
        chk({tag, "_valid"}, int'(cmd_valid), int'(exp_q.size() != 0));
        chk({tag, "_held"}, int'(held), int'(m_held));
        chk({tag, "_ovf"}, int'(overflow), int'(m_ovf));
    endtask

    task automatic release_all();
        send(8'h1C, 1'b1, 1'b0, 2);
        send(8'h23, 1'b1, 1'b0, 2);
        send(8'h29, 1'b1, 1'b0, 2);
        send(8'h76, 1'b1, 1'b0, 2);
    endtask

    // Monitor: every accepted pop must present the model's head command.
    always @(negedge clk) begin
        if (!rst && cmd_rd && cmd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got cmd %0d expected empty", cmd);
            end else begin
                last_pop = exp_q.pop_front();
                if (int'(cmd) != last_pop) begin
                    errors++;
                    $display("FAIL pop_cmd: got %0d expected %0d", cmd, last_pop);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool [8];
        pool[0] = 8'h6B; pool[1] = 8'h74; pool[2] = 8'h1C; pool[3] = 8'h23;
        pool[4] = 8'h29; pool[5] = 8'h5A; pool[6] = 8'h76; pool[7] = 8'h15;

        // Reset then idle.
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check_state("reset");
        chk("reset_cmd", int'(cmd), 0);

        // LEFT via E0 6B: exact 3-edge latency.
        key = 8'h6B; expand_key = 1'b1; key_released = 1'b0; done = 1'b1;
        model_event(8'h6B, 1'b0, 1'b1);
        tick();
        tick();
        done = 1'b0;
        tick();
        chk("lat_before", int'(cmd_valid), 0);
        tick();
        chk("lat_at", int'(cmd_valid), 1);
        chk("lat_cmd", int'(cmd), 1);
        chk("lat_held", int'(held), 1);
        pop1();
        chk("lat_pop_count", int'(count), 0);
        chk("lat_pop_cmd", int'(cmd), 0);
        send(8'h6B, 1'b1, 1'b1, 2);

        // Typematic filtering of RIGHT.
        for (int i = 0; i < 5; i++) send(8'h23, 1'b0, 1'b0, 2 + i % 3);
        chk("typ_count", int'(count), 1);
        send(8'h23, 1'b1, 1'b0, 2);
        send(8'h23, 1'b0, 1'b0, 3);
        chk("typ_count2", int'(count), 2);
        chk("typ_held1", int'(held[1]), 1);
        check_state("typ");
        pop1(); pop1();
        release_all();

        // Overflow on a fifth push, then pop order and clear.
        send(8'h29, 1'b0, 1'b0, 2);
        send(8'h76, 1'b0, 1'b0, 2);
        send(8'h1C, 1'b0, 1'b0, 2);
        send(8'h23, 1'b0, 1'b0, 2);
        send(8'h29, 1'b1, 1'b0, 2);
        send(8'h5A, 1'b0, 1'b0, 2);
        chk("ovf_count", int'(count), 4);
        chk("ovf_flag", int'(overflow), 1);
        check_state("ovf");
        repeat (4) pop1();
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0; m_ovf = 1'b0; tick();
        chk("ovf_clear", int'(overflow), 0);
        release_all();
        send(8'h5A, 1'b1, 1'b0, 2);

        // Full FIFO with the fifth push coincident with a pop.
        send(8'h29, 1'b0, 1'b0, 2);
        send(8'h76, 1'b0, 1'b0, 2);
        send(8'h1C, 1'b0, 1'b0, 2);
        send(8'h23, 1'b0, 1'b0, 2);
        key = 8'h74; expand_key = 1'b1; key_released = 1'b0; done = 1'b1;
        m_held[1] = 1'b0;
        send(8'h74, 1'b1, 1'b1, 2);
        key = 8'h74; expand_key = 1'b1; key_released = 1'b0; done = 1'b1;
        m_held[1] = 1'b1;
        exp_q.push_back(2);
        tick();
        tick();
        done = 1'b0;
        tick();
        cmd_rd = 1'b1;
        tick();
        cmd_rd = 1'b0;
        tick();
        chk("coinc_count", int'(count), 4);
        chk("coinc_ovf", int'(overflow), 0);
        repeat (4) pop1();
        chk("coinc_tail", last_pop, 2);
        release_all();

        // Unmapped codes, en=0, then reset with entries queued.
        send(8'h15, 1'b0, 1'b0, 2);
        send(8'h6B, 1'b0, 1'b0, 2);
        chk("unmapped_count", int'(count), 0);
        send(8'h29, 1'b0, 1'b0, 2);
        en = 1'b0; m_held = 4'b0000; tick(); tick();
        send(8'h5A, 1'b0, 1'b0, 2);
        chk("en0_held", int'(held), 0);
        chk("en0_count", int'(count), 1);
        en = 1'b1; tick();
        send(8'h76, 1'b0, 1'b0, 2);
        send(8'h1C, 1'b0, 1'b0, 2);
        chk("pre_rst_count", int'(count), 3);
        rst = 1'b1;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(cmd_valid), 0);
        exp_q.delete(); m_held = 4'b0000; m_ovf = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_state("post_rst");

        // Randomized serialized traffic against the model.
        for (int it = 0; it < 250; it++) begin
            int a;
            a = $urandom_range(0, 9);
            if (a < 6) begin
                send(pool[$urandom_range(0, 7)], 1'($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 1)), $urandom_range(2, 4));
            end else if (a < 8) begin
                if (exp_q.size() != 0) pop1();
                else begin cmd_rd = 1'b1; tick(); cmd_rd = 1'b0; tick(); end
            end else if (a == 8) begin
                clr_ovf = 1'b1; tick(); clr_ovf = 1'b0; m_ovf = 1'b0; tick();
            end else begin
                en = ~en;
                if (!en) m_held = 4'b0000;
                tick(); tick();
            end
            check_state("rand");
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_cmd_queue.md
Name: key_cmd_queue

Overview:
- Sits directly downstream of ps2_keyboard_driver and upstream of move/change_scene.
- Replaces the ad-hoc done/key shift queues with a synchronized, decoded command stream.
- Converts raw PS/2 events (done, key, key_released, expand_key) into game commands LEFT/RIGHT/START/QUIT.
- Suppresses typematic auto-repeat and buffers commands in a small first-word-fall-through FIFO that consumers pop.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  system clock (100 MHz board clock).
- rst  input  1  asynchronous active-high reset.
- en  input  1  command capture enable; low = events discarded, held mask cleared.
- done  input  1  driver data-ready level/pulse, asynchronous to clk domain logic; always at least 2 clk wide.
- key  input  8  PS/2 scan code, valid while done high.
- key_released  input  1  1 = break event.
- expand_key  input  1  1 = E0-prefixed code.
- cmd_rd  input  1  pop head entry (single-cycle strobe).
- clr_ovf  input  1  clears overflow flag.
- cmd_valid  output  1  FIFO non-empty.
- cmd  output  3  head command: 1 LEFT, 2 RIGHT, 3 START, 4 QUIT; 0 when empty.
- held  output  4  bit i-1 = command i key currently held.
- count  output  PTR_W+1  entries stored, 0..DEPTH.
- overflow  output  1  sticky: a command was dropped.

Behaviour:
- Reset (async, rst=1): sync regs 0, held=0, FIFO pointers 0, count=0, cmd_valid=0, cmd=0, overflow=0. Reset mid-operation discards all queued and in-flight events.
- Input sync: done through 3 flops d1,d2,d3. key, key_released and expand_key are captured into the same pipeline alongside d1 and d2.
- Event strobe: ev = d2 & ~d3. Exactly one strobe per done rising edge, regardless of done width.
- Decode mapping (registered, one cycle after ev):
  - LEFT: expand=1 & key=8'h6B, or expand=0 & key=8'h1C ('A').
  - RIGHT: expand=1 & key=8'h74, or expand=0 & key=8'h23 ('D').
  - START: expand=0 & key in {8'h29, 8'h5A}.
  - QUIT: expand=0 & key=8'h76.
  - All other codes are ignored.
- Held/repeat filter, mapped command c:
  - Make event with held[c]=0: set held[c], request push of c.
  - Make event with held[c]=1: typematic repeat; no push.
  - Break event: clear held[c]; no push.
- Latency: done first sampled high at edge k -> push at edge k+3 -> cmd_valid/cmd updated after edge k+3 (FWFT: cmd = head entry combinationally from storage).
- FIFO:
  - Push and pop occur on the same edge.
  - Pop when empty: ignored, no state change.
  - Push when count=DEPTH and no pop: entry dropped, overflow<=1.
  - Push when full with cmd_rd=1: both occur, count stays DEPTH, no overflow.
  - Push with pop when count=1: count stays 1, new entry becomes head.
  - Pointers wrap modulo DEPTH. count is the write/read difference, width PTR_W+1.
- overflow: set takes priority over clr_ovf on the same cycle; otherwise clr_ovf clears it.
- en=0:
  - ev still shifts through the sync pipeline, but decode pushes nothing.
  - held forced to 0.
  - FIFO contents and pops unaffected.
  - On en rising, a key already physically down re-issues on its next typematic make, which is intended resume behaviour.
- Simultaneous ev and en falling edge: en sampled in the decode cycle governs.

Test Plan:
- Reset then idle -> cmd_valid=0, cmd=0, count=0, overflow=0, held=0.
- done 2-clk pulse with key=8'h6B, expand=1, rel=0 -> cmd_valid rises exactly 3 edges after first sampled done, cmd=1, held=4'b0001; cmd_rd pulse -> count=0, cmd=0.
- Five makes of 8'h23 with no break in between -> count=1 (typematic filtered); then break 8'h23 and make 8'h23 -> count=2, held[1]=1.
- DEPTH=4: push START, QUIT, LEFT, RIGHT, then a fifth START -> count=4, overflow=1, pop order 3,4,1,2; clr_ovf -> overflow=0.
- Full FIFO, fifth push coincident with cmd_rd -> count=4, overflow=0, tail entry=new command.
- Unmapped code 8'h15, and 8'h6B with expand=0 -> no push; en=0 with make 8'h29 -> no push, held=0; rst asserted with count=3 -> immediately count=0, cmd_valid=0.
